// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs the ibus req/ack handshake and
// feeds the fetched word plus its PC to IF/ID, honouring stall, branch and flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {S_RST, S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] ibuf_q, ibuf_d;

    logic        req_ack;
    logic        inst_vld;
    logic [31:0] seq_pc;
    logic        unused_stall;

    assign unused_stall = ^stall[5:1];

    assign req_ack = (state_q == S_REQ) && ibus_ack_i;
    // Branch is only meaningful on the cycle the delay-slot instruction is consumed.
    assign seq_pc  = branch_flag_i ? branch_target_address_i : pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        ibuf_d    = ibuf_q;
        case (state_q)
            S_RST: begin
                state_d = S_REQ;
                if (flush) pc_d = new_pc;
            end
            S_REQ: begin
                if (flush) begin
                    if (ibus_ack_i) begin
                        pc_d = new_pc;
                    end else begin
                        pend_pc_d = new_pc;
                        state_d   = S_DROP;
                    end
                end else if (ibus_ack_i) begin
                    if (!stall[0]) begin
                        pc_d = seq_pc;
                    end else begin
                        ibuf_d  = ibus_rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = new_pc;
                    state_d = S_REQ;
                end else if (!stall[0]) begin
                    pc_d    = seq_pc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // The stale access must complete before the redirect can be issued.
                if (ibus_ack_i) begin
                    pc_d    = flush ? new_pc : pend_pc_q;
                    state_d = S_REQ;
                end else if (flush) begin
                    pend_pc_d = new_pc;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'd0;
            ibuf_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            ibuf_q    <= ibuf_d;
        end
    end

    assign ibus_req_o  = !rst && ((state_q == S_REQ) || (state_q == S_DROP));
    assign ibus_addr_o = {pc_q[31:2], 2'b00};
    assign stallreq_o  = rst || (state_q == S_RST) || (state_q == S_DROP) ||
                         ((state_q == S_REQ) && !ibus_ack_i);

    assign inst_vld  = !rst && !flush && (req_ack || (state_q == S_HOLD));
    assign if_pc_o   = inst_vld ? pc_q : 32'd0;
    assign if_inst_o = !inst_vld ? 32'd0 :
                       (state_q == S_HOLD) ? ibuf_q : ibus_rdata_i;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a latency-programmable memory returns the
// address as data; every consumed instruction is popped and compared.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_o;

    int checks = 0;
    int fails  = 0;
    int lat    = 0;
    int cnt    = 0;
    logic force_ack = 1'b0;
    logic [31:0] exp_q[$];

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req_o              (ibus_req_o),
        .ibus_addr_o             (ibus_addr_o),
        .ibus_ack_i              (ibus_ack_i),
        .ibus_rdata_i            (ibus_rdata_i),
        .if_pc_o                 (if_pc_o),
        .if_inst_o               (if_inst_o),
        .stallreq_o              (stallreq_o)
    );

    always #5 clk = ~clk;

    // Memory: ack after `lat` wait cycles; force_ack injects a stray ack with junk data.
    always @(posedge clk) begin
        if (rst || !ibus_req_o || ibus_ack_i) cnt <= 0;
        else                                  cnt <= cnt + 1;
    end
    assign ibus_ack_i   = force_ack | (ibus_req_o && (cnt == lat));
    assign ibus_rdata_i = force_ack ? 32'hBAD0_BAD0 : ibus_addr_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // An instruction is consumed when fetch is ready and IF/ID is not stalled.
    always @(negedge clk) begin
        if (!rst && !stallreq_o && !stall[0] && !flush) begin
            if (exp_q.size() == 0) begin
                chk("extra_fetch_pc", if_pc_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("if_pc", if_pc_o, e);
                chk("if_inst", if_inst_o, e);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        force_ack = 1'b0; lat = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic run_until_empty(input int maxc, output int stalls);
        logic        pend;
        logic [31:0] paddr;
        stalls = 0; pend = 1'b0; paddr = '0;
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) return;
            if (pend) chk("addr_hold", ibus_addr_o, paddr);
            if (stallreq_o) stalls++;
            pend  = ibus_req_o && !ibus_ack_i;
            paddr = ibus_addr_o;
            @(posedge clk);
            #1;
        end
        chk("run_timeout_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int st;

        // Reset values while rst is held.
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(ibus_req_o), 32'd0);
        chk("rst_addr", ibus_addr_o, 32'h0);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_if_inst", if_inst_o, 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'd1);

        // Zero-wait streaming.
        do_reset();
        chk("srst_req", 32'(ibus_req_o), 32'd0);
        chk("srst_stallreq", 32'(stallreq_o), 32'd1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        run_until_empty(20, st);
        chk("zw_stall_cycles", 32'(st), 32'd1);

        // Two-cycle ack latency.
        do_reset();
        lat = 2;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        run_until_empty(30, st);
        chk("lat2_stall_cycles", 32'(st), 32'd5);

        // stall[0] on the ack of 0x8 for three cycles.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        run_until_empty(20, st);
        chk("pre_hold_addr", ibus_addr_o, 32'h8);
        stall = 6'b000001;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("hold_req", 32'(ibus_req_o), 32'd0);
            chk("hold_inst", if_inst_o, 32'h8);
            chk("hold_pc", if_pc_o, 32'h8);
            chk("hold_stallreq", 32'(stallreq_o), 32'd0);
        end
        @(posedge clk); #1;
        stall = '0;
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        #1;
        run_until_empty(20, st);
        chk("hold_rel_stalls", 32'(st), 32'd0);

        // Taken branch on the ack of 0x10.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        run_until_empty(20, st);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        exp_q.push_back(32'h10); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        @(posedge clk); #1;
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        #1;
        chk("br_addr", ibus_addr_o, 32'h100);
        run_until_empty(20, st);
        chk("br_stalls", 32'(st), 32'd0);

        // Flush to 0x180 while the access to 0x20 is still pending.
        do_reset();
        for (int a = 0; a < 32'h20; a += 4) exp_q.push_back(32'(a));
        run_until_empty(40, st);
        lat = 2; flush = 1'b1; new_pc = 32'h180;
        #1;
        chk("fl_addr", ibus_addr_o, 32'h20);
        chk("fl_inst", if_inst_o, 32'h0);
        chk("fl_pc", if_pc_o, 32'h0);
        chk("fl_stallreq", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; new_pc = 32'h0;
        #1;
        chk("drop_req", 32'(ibus_req_o), 32'd1);
        chk("drop_addr", ibus_addr_o, 32'h20);
        chk("drop_stallreq", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        chk("drop_ack", 32'(ibus_ack_i), 32'd1);
        chk("drop_ack_addr", ibus_addr_o, 32'h20);
        chk("drop_ack_inst", if_inst_o, 32'h0);
        chk("drop_ack_stallreq", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        chk("redir_addr", ibus_addr_o, 32'h180);
        exp_q.push_back(32'h180);
        run_until_empty(20, st);
        chk("redir_stalls", 32'(st), 32'd2);

        // Reset with a request outstanding, stray ack the following cycle.
        do_reset();
        lat = 2;
        @(posedge clk); #1;
        chk("mid_req_before", 32'(ibus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(ibus_req_o), 32'd0);
        chk("mid_rst_stallreq", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; force_ack = 1'b1; lat = 0;
        #1;
        chk("late_ack_req", 32'(ibus_req_o), 32'd0);
        chk("late_ack_inst", if_inst_o, 32'h0);
        chk("late_ack_pc", if_pc_o, 32'h0);
        chk("late_ack_stallreq", 32'(stallreq_o), 32'd1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        @(posedge clk); #1;
        force_ack = 1'b0;
        #1;
        chk("restart_addr", ibus_addr_o, 32'h0);
        run_until_empty(20, st);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
